full_adder: RTL and testbench



---
 rtl/full_adder_pkg.sv | 8 +
 rtl/full_adder_bit.sv | 11 +
 rtl/full_adder.sv | 51 +++++
 tb/tb_full_adder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared width default and packed result type for full_adder
package full_adder_pkg;
  localparam int FA_WIDTH_DEF = 3;
  typedef struct packed {
    logic                    c;
    logic [FA_WIDTH_DEF-1:0] s;
  } fa_res_t;
endpackage

// File: rtl/full_adder_bit.sv
// full_adder_bit: 1-bit full-adder cell
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/full_adder.sv
// full_adder: registered ripple-carry adder; FULL_ADDER_OVF_EN adds the registered signed-overflow port ovf
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
`ifdef FULL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s;
  assign carry[0] = c_in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (s[i]),
      .co (carry[i+1])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s;
        c_out <= carry[WIDTH];
      end
    end
  end
`ifdef FULL_ADDER_OVF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) ovf <= 1'b0;
    else if (in_valid) ovf <= carry[WIDTH] ^ carry[WIDTH-1];
  end
`endif
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed self-checking bench for the 3-bit registered adder
module tb_full_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] a = '0;
  logic [2:0] b = '0;
  logic       c_in = 1'b0;
  logic [2:0] sum;
  logic       c_out;
  logic       out_valid;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf;
`endif
  int errors = 0;
  int checks = 0;
  full_adder #(.WIDTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sum       (sum),
    .c_out     (c_out),
`ifdef FULL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [2:0] va, input logic [2:0] vb, input logic vc, input logic vv);
    a = va;
    b = vb;
    c_in = vc;
    in_valid = vv;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    for (int n = 0; n < 2; n++) begin
      step(3'd5, 3'd5, 1'b0, 1'b1);
      checks += 3;
      if (sum !== 3'd0) begin errors++; $display("FAIL reset_sum got=%0d exp=0", sum); end
      if (c_out !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", c_out); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
`ifdef FULL_ADDER_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    end
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    step(3'd1, 3'd0, 1'b0, 1'b1);
    checks += 3;
    if (sum !== 3'd1) begin errors++; $display("FAIL basic_sum got=%0d exp=1", sum); end
    if (c_out !== 1'b0) begin errors++; $display("FAIL basic_cout got=%b exp=0", c_out); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
  endtask
  task automatic test_carry();
    step(3'd3, 3'd7, 1'b0, 1'b1);
    checks += 2;
    if (sum !== 3'd2) begin errors++; $display("FAIL carry_sum got=%0d exp=2", sum); end
    if (c_out !== 1'b1) begin errors++; $display("FAIL carry_cout got=%b exp=1", c_out); end
    step(3'd5, 3'd1, 1'b0, 1'b1);
    checks += 2;
    if (sum !== 3'd6) begin errors++; $display("FAIL nocarry_sum got=%0d exp=6", sum); end
    if (c_out !== 1'b0) begin errors++; $display("FAIL nocarry_cout got=%b exp=0", c_out); end
  endtask
  task automatic test_wrap();
    step(3'd7, 3'd7, 1'b1, 1'b1);
    checks += 2;
    if (sum !== 3'd7) begin errors++; $display("FAIL wrap_sum got=%0d exp=7", sum); end
    if (c_out !== 1'b1) begin errors++; $display("FAIL wrap_cout got=%b exp=1", c_out); end
  endtask
`ifdef FULL_ADDER_OVF_EN
  task automatic test_ovf();
    step(3'd3, 3'd1, 1'b0, 1'b1);
    checks += 2;
    if (sum !== 3'd4) begin errors++; $display("FAIL ovf_sum got=%0d exp=4", sum); end
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf); end
    step(3'd1, 3'd0, 1'b0, 1'b1);
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
  endtask
`endif
  task automatic test_back_to_back();
    logic [2:0] ta [4] = '{3'd2, 3'd4, 3'd6, 3'd0};
    logic [2:0] tb [4] = '{3'd3, 3'd4, 3'd1, 3'd0};
    logic       tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0] es [4] = '{3'd5, 3'd0, 3'd0, 3'd1};
    logic       ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int n = 0; n < 4; n++) begin
      step(ta[n], tb[n], tc[n], 1'b1);
      checks += 3;
      if (sum !== es[n]) begin errors++; $display("FAIL b2b_sum[%0d] got=%0d exp=%0d", n, sum, es[n]); end
      if (c_out !== ec[n]) begin errors++; $display("FAIL b2b_cout[%0d] got=%b exp=%b", n, c_out, ec[n]); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=1", n, out_valid); end
    end
  endtask
  task automatic test_hold_reset();
    step(3'd3, 3'd7, 1'b0, 1'b1);
    for (int n = 0; n < 2; n++) begin
      step(3'bxxx, 3'bzzz, 1'bx, 1'b0);
      checks += 3;
      if (sum !== 3'd2) begin errors++; $display("FAIL hold_sum got=%0d exp=2", sum); end
      if (c_out !== 1'b1) begin errors++; $display("FAIL hold_cout got=%b exp=1", c_out); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid got=%b exp=0", out_valid); end
    end
    rst_n = 1'b0;
    step(3'd5, 3'd5, 1'b0, 1'b1);
    checks += 3;
    if (sum !== 3'd0) begin errors++; $display("FAIL midrst_sum got=%0d exp=0", sum); end
    if (c_out !== 1'b0) begin errors++; $display("FAIL midrst_cout got=%b exp=0", c_out); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    rst_n = 1'b1;
    step(3'd1, 3'd1, 1'b0, 1'b1);
    checks += 2;
    if (sum !== 3'd2) begin errors++; $display("FAIL postrst_sum got=%0d exp=2", sum); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL postrst_valid got=%b exp=1", out_valid); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_wrap();
`ifdef FULL_ADDER_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    test_hold_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
